// File: rtl/duty_pwm_gen.sv
// duty_pwm_gen: multi-channel programmable duty-cycle generator.
// ON/OFF counts are double-buffered and committed only at period boundaries or on start.
module duty_pwm_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] on_time,
    input  logic [CHANNELS*WIDTH-1:0] off_time,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS-1:0]       period_done,
    output logic [CHANNELS-1:0]       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] w_cnt_nxt;
        logic [WIDTH-1:0] r_act_on;
        logic [WIDTH-1:0] r_act_off;
        logic [WIDTH-1:0] w_act_on_nxt;
        logic [WIDTH-1:0] w_act_off_nxt;
        logic [WIDTH-1:0] r_pend_on;
        logic [WIDTH-1:0] r_pend_off;
        logic [WIDTH-1:0] w_pend_on_nxt;
        logic [WIDTH-1:0] w_pend_off_nxt;
        logic             r_pend_valid;
        logic             w_pend_valid_nxt;
        logic             r_pwm;
        logic             r_done;
        logic             r_busy;
        logic             w_done_nxt;
        logic             w_commit;
        logic [WIDTH-1:0] w_ld_on;
        logic [WIDTH-1:0] w_ld_off;
        logic [WIDTH-1:0] w_cm_on;
        logic [WIDTH-1:0] w_cm_off;

        assign w_ld_on  = on_time[gi*WIDTH +: WIDTH];
        assign w_ld_off = off_time[gi*WIDTH +: WIDTH];

        // Values a commit would take: a same-edge load bypasses the pending buffer.
        always_comb begin
            w_cm_on  = r_act_on;
            w_cm_off = r_act_off;
            if (load[gi]) begin
                w_cm_on  = w_ld_on;
                w_cm_off = w_ld_off;
            end else if (r_pend_valid) begin
                w_cm_on  = r_pend_on;
                w_cm_off = r_pend_off;
            end
        end

        always_comb begin
            w_state_nxt      = r_state;
            w_cnt_nxt        = r_cnt;
            w_act_on_nxt     = r_act_on;
            w_act_off_nxt    = r_act_off;
            w_pend_on_nxt    = r_pend_on;
            w_pend_off_nxt   = r_pend_off;
            w_pend_valid_nxt = r_pend_valid;
            w_commit         = 1'b0;
            w_done_nxt       = 1'b0;

            if (load[gi]) begin
                w_pend_on_nxt    = w_ld_on;
                w_pend_off_nxt   = w_ld_off;
                w_pend_valid_nxt = 1'b1;
            end

            if (!en[gi]) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: w_commit = 1'b1;
                    ST_HIGH: begin
                        if (r_cnt != CNT_ZERO) begin
                            w_cnt_nxt = r_cnt - CNT_ONE;
                        end else if (r_act_off != CNT_ZERO) begin
                            w_state_nxt = ST_LOW;
                            w_cnt_nxt   = r_act_off - CNT_ONE;
                        end else begin
                            w_commit = 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (r_cnt != CNT_ZERO) begin
                            w_cnt_nxt = r_cnt - CNT_ONE;
                        end else begin
                            w_commit = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                endcase

                // Period start: ON phase first, else OFF phase, else a 1-cycle low period.
                if (w_commit) begin
                    w_act_on_nxt     = w_cm_on;
                    w_act_off_nxt    = w_cm_off;
                    w_pend_valid_nxt = 1'b0;
                    if (w_cm_on != CNT_ZERO) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = w_cm_on - CNT_ONE;
                    end else if (w_cm_off != CNT_ZERO) begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = w_cm_off - CNT_ONE;
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
            end

            // Next cycle is the last of its period.
            w_done_nxt = ((w_state_nxt == ST_HIGH) && (w_cnt_nxt == CNT_ZERO)
                          && (w_act_off_nxt == CNT_ZERO))
                      || ((w_state_nxt == ST_LOW) && (w_cnt_nxt == CNT_ZERO));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state      <= ST_IDLE;
                r_cnt        <= CNT_ZERO;
                r_act_on     <= CNT_ZERO;
                r_act_off    <= CNT_ZERO;
                r_pend_on    <= CNT_ZERO;
                r_pend_off   <= CNT_ZERO;
                r_pend_valid <= 1'b0;
                r_pwm        <= 1'b0;
                r_done       <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                r_state      <= w_state_nxt;
                r_cnt        <= w_cnt_nxt;
                r_act_on     <= w_act_on_nxt;
                r_act_off    <= w_act_off_nxt;
                r_pend_on    <= w_pend_on_nxt;
                r_pend_off   <= w_pend_off_nxt;
                r_pend_valid <= w_pend_valid_nxt;
                r_pwm        <= (w_state_nxt == ST_HIGH);
                r_done       <= w_done_nxt;
                r_busy       <= (w_state_nxt != ST_IDLE);
            end
        end

        assign pwm_out[gi]     = r_pwm;
        assign period_done[gi] = r_done;
        assign busy[gi]        = r_busy;
    end

endmodule

// File: tb/tb_duty_pwm_gen.sv
// tb_duty_pwm_gen: self-checking bench for duty_pwm_gen with WIDTH=8, CHANNELS=2.
// Per-channel expected {pwm, done, busy} are queued at drive time and popped after each edge.
module tb_duty_pwm_gen;

    typedef struct packed {
        logic pwm;
        logic done;
        logic busy;
    } exp_t;

    typedef struct {
        logic [7:0] on0;
        logic [7:0] off0;
        int         hi0;
        int         per0;
        logic [7:0] on1;
        logic [7:0] off1;
        int         hi1;
        int         per1;
        int         cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  en;
    logic [1:0]  load;
    logic [15:0] on_time;
    logic [15:0] off_time;
    logic [1:0]  pwm_out;
    logic [1:0]  period_done;
    logic [1:0]  busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    vec_t vecs[4];

    duty_pwm_gen #(.WIDTH(8), .CHANNELS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .on_time    (on_time),
        .off_time   (off_time),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input int ch, input exp_t e);
        if (ch == 0) exp_q0.push_back(e);
        else         exp_q1.push_back(e);
    endfunction

    function automatic void push_idle(input int ch, input int n);
        exp_t e;
        e = '0;
        for (int t = 0; t < n; t++) push_exp(ch, e);
    endfunction

    // n cycles of a running channel: high for hi cycles of each per-cycle period
    function automatic void push_run(input int ch, input int hi, input int per, input int n);
        exp_t e;
        for (int t = 0; t < n; t++) begin
            e.pwm  = ((t % per) < hi);
            e.done = ((t % per) == (per - 1));
            e.busy = 1'b1;
            push_exp(ch, e);
        end
    endfunction

    task automatic check_ch(input int ch, input string tag);
        exp_t a;
        exp_t e;
        int   sz;
        a = {pwm_out[ch], period_done[ch], busy[ch]};
        sz = (ch == 0) ? exp_q0.size() : exp_q1.size();
        checks++;
        if (sz == 0) begin
            errors++;
            $display("FAIL %s ch%0d cyc%0d: no expected entry, got pwm/done/busy=%b", tag, ch, cyc, a);
            return;
        end
        if (ch == 0) e = exp_q0.pop_front();
        else         e = exp_q1.pop_front();
        if (a !== e) begin
            errors++;
            $display("FAIL %s ch%0d cyc%0d: pwm/done/busy got %b required %b", tag, ch, cyc, a, e);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({pwm_out, period_done, busy} !== 6'b0) begin
            errors++;
            $display("FAIL %s: pwm=%b done=%b busy=%b required all 0", tag, pwm_out, period_done, busy);
        end
    endtask

    task automatic drive(input logic [1:0] ld, input logic [1:0] e,
                         input logic [7:0] on0, input logic [7:0] off0,
                         input logic [7:0] on1, input logic [7:0] off1);
        load     = ld;
        en       = e;
        on_time  = {on1, on0};
        off_time = {off1, off0};
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        check_ch(0, tag);
        check_ch(1, tag);
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        en   = 2'b00;
        load = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_async"});
        @(posedge clk);
        #1;
        check_zero({tag, "_held"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 2'b00;
        load     = 2'b00;
        on_time  = 16'h0;
        off_time = 16'h0;

        vecs[0] = '{on0: 8'd4,   off0: 8'd7,   hi0: 4,   per0: 11,
                    on1: 8'd1,   off1: 8'd1,   hi1: 1,   per1: 2,  cycles: 33};
        vecs[1] = '{on0: 8'd5,   off0: 8'd0,   hi0: 5,   per0: 5,
                    on1: 8'd0,   off1: 8'd6,   hi1: 0,   per1: 6,  cycles: 20};
        vecs[2] = '{on0: 8'd0,   off0: 8'd0,   hi0: 0,   per0: 1,
                    on1: 8'd2,   off1: 8'd3,   hi1: 2,   per1: 5,  cycles: 10};
        vecs[3] = '{on0: 8'd255, off0: 8'd255, hi0: 255, per0: 510,
                    on1: 8'd3,   off1: 8'd1,   hi1: 3,   per1: 4,  cycles: 520};

        @(negedge clk);
        do_reset("reset_init");

        // Table-driven steady-state patterns, both channels loaded and enabled together.
        for (int v = 0; v < 4; v++) begin
            push_run(0, vecs[v].hi0, vecs[v].per0, vecs[v].cycles);
            push_run(1, vecs[v].hi1, vecs[v].per1, vecs[v].cycles);
            for (int i = 0; i < vecs[v].cycles; i++) begin
                drive((i == 0) ? 2'b11 : 2'b00, 2'b11,
                      vecs[v].on0, vecs[v].off0, vecs[v].on1, vecs[v].off1);
                cycle($sformatf("vec%0d", v));
            end
            do_reset($sformatf("reset_vec%0d", v));
        end

        // Load 2/3 while HIGH of a 4/7 period: current period completes unchanged.
        push_run(0, 4, 11, 11);
        push_run(0, 2, 5, 15);
        push_idle(1, 26);
        for (int i = 0; i < 26; i++) begin
            drive({1'b0, (i == 0 || i == 2)}, 2'b01,
                  (i == 0) ? 8'd4 : 8'd2, (i == 0) ? 8'd7 : 8'd3, 8'd0, 8'd0);
            cycle("midhigh_load");
        end
        do_reset("reset_midhigh");

        // Boundary-edge load 3/3, then two loads in one period where the last (1/1) wins.
        push_run(0, 4, 11, 11);
        push_run(0, 3, 6, 6);
        push_run(0, 1, 2, 8);
        push_idle(1, 25);
        for (int i = 0; i < 25; i++) begin
            if (i == 0)       drive(2'b01, 2'b01, 8'd4, 8'd7, 8'd0, 8'd0);
            else if (i == 11) drive(2'b01, 2'b01, 8'd3, 8'd3, 8'd0, 8'd0);
            else if (i == 12) drive(2'b01, 2'b01, 8'd6, 8'd2, 8'd0, 8'd0);
            else if (i == 14) drive(2'b01, 2'b01, 8'd1, 8'd1, 8'd0, 8'd0);
            else              drive(2'b00, 2'b01, 8'd0, 8'd0, 8'd0, 8'd0);
            cycle("boundary_load");
        end
        do_reset("reset_boundary");

        // ch0 enable dropped in its 3rd HIGH cycle, then re-enabled; ch1 keeps running 1/1.
        push_run(0, 4, 11, 3);
        push_idle(0, 3);
        push_run(0, 4, 11, 11);
        push_run(1, 1, 2, 17);
        for (int i = 0; i < 17; i++) begin
            drive((i == 0) ? 2'b11 : 2'b00, {1'b1, !(i >= 3 && i <= 5)},
                  8'd4, 8'd7, 8'd1, 8'd1);
            cycle("en_drop");
        end

        // Reset mid-period with both channels busy, then independent restart.
        do_reset("reset_midrun");
        push_run(0, 4, 11, 7);
        push_run(1, 1, 2, 7);
        for (int i = 0; i < 7; i++) begin
            drive((i == 0) ? 2'b11 : 2'b00, 2'b11, 8'd4, 8'd7, 8'd1, 8'd1);
            cycle("pre_reset");
        end
        do_reset("reset_async_mid");
        push_run(0, 4, 11, 22);
        push_run(1, 1, 2, 22);
        for (int i = 0; i < 22; i++) begin
            drive((i == 0) ? 2'b11 : 2'b00, 2'b11, 8'd4, 8'd7, 8'd1, 8'd1);
            cycle("post_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/duty_pwm_gen.md
Name: duty_pwm_gen

Overview:
Synthesizable, multi-channel, programmable duty-cycle generator. It is the next generation of the testbench-only duty clock model. Each channel drives a registered square wave that is high for ON cycles and low for OFF cycles of clk. New ON/OFF values are double-buffered and take effect only at a period boundary, so no partial periods (glitches) appear. The block serves as the stimulus/clock-enable source for switch-level and PWM blocks in the design.

Parameters:
WIDTH, 8, bit width of each ON/OFF count (max 2^WIDTH-1 cycles per phase)
CHANNELS, 2, number of independent PWM channels

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  CHANNELS  per-channel run enable
load  input  CHANNELS  per-channel strobe: capture ON/OFF slice into pending register
on_time  input  CHANNELS*WIDTH  ON count; channel i uses bits [i*WIDTH +: WIDTH]
off_time  input  CHANNELS*WIDTH  OFF count, same slicing
pwm_out  output  CHANNELS  registered PWM output
period_done  output  CHANNELS  1-cycle pulse during the last cycle of each completed period
busy  output  CHANNELS  1 while channel is not IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pwm_out=0, period_done=0, busy=0
  - all channels go to IDLE
  - active and pending ON/OFF registers = 0; pending_valid = 0
- Channels are fully independent; the description below is per channel i.
- Registers per channel: pending_on/off + pending_valid, active_on/off, down-counter cnt[WIDTH-1:0], state.
- load[i]=1 at an edge:
  - pending_on/off <= the channel slices; pending_valid <= 1
  - a later load before the boundary overwrites the pending values (last write wins)
- Commit point: active <= pending and pending_valid <= 0 in exactly two cases:
  - at the boundary edge (the edge closing the last cycle of a period)
  - at the edge leaving IDLE
  - If load is asserted on that same edge, the load values bypass and are committed directly.
- States:
  - IDLE: pwm_out=0. If en[i]=1, commit, then:
    - ON>0: go to HIGH with cnt=ON-1
    - ON=0, OFF>0: go to LOW with cnt=OFF-1
    - ON=0, OFF=0: go to LOW with cnt=0
  - HIGH: pwm_out=1.
    - cnt>0: decrement
    - cnt=0 and OFF>0: go to LOW, cnt=OFF-1
    - cnt=0 and OFF=0: period ends; commit and restart (100% duty, output never drops)
  - LOW: pwm_out=0.
    - cnt>0: decrement
    - cnt=0: period ends; commit and restart per the IDLE start rules, using the committed values
- Output timing:
  - pwm_out and busy reflect the state registered at the edge. No combinational path from any input to any output.
  - Latency: en sampled 1 at edge k gives the first HIGH cycle between edge k and edge k+1.
- Period length = ON+OFF cycles, minimum 1. Both zero gives constant low with period_done every cycle.
- period_done=1 exactly during the cycle whose closing edge is a period boundary, so there is one pulse per period.
- en[i]=0 sampled at any edge (mid-period included):
  - next state IDLE, pwm_out=0, period_done=0
  - active values retained; pending retained
  - Re-enable starts a fresh period from HIGH, with no resume of the old count.
- Maximum counts (2^WIDTH-1) must work; cnt never underflows or wraps.
- Asynchronous reset mid-period: outputs go low immediately; no state survives.

Test Plan:
- ON=4, OFF=7, en=1 held -> pwm_out repeats 4 high / 7 low, period 11; period_done pulses every 11 cycles, coincident with the 7th low cycle.
- Running 4/7, load 2/3 mid-HIGH -> the current period finishes as 4/7, then 2/3 periods follow; no short or long period is observed.
- Corner counts: ON=5, OFF=0 -> pwm_out constant 1, period_done every 5 cycles. ON=0, OFF=6 -> constant 0. ON=0, OFF=0 -> constant 0, period_done every cycle. ON=255, OFF=255 (WIDTH=8) -> 255/255, no wrap.
- en drop: en=0 during cycle 3 of HIGH (ON=4, OFF=7) -> pwm_out=0 from the next edge, busy=0. Re-enable -> a full 4-cycle HIGH starts.
- Loads at the boundary: load 3/3 on the boundary edge -> the new values apply to the immediately following period. Two loads in one period (6/2 then 1/1) -> only 1/1 is applied.
- Reset and channel independence: CHANNELS=2, ch0 at 4/7 and ch1 at 1/1, rst_n pulsed low mid-period -> all outputs 0 asynchronously. After release, with load+en, both channels run independently with the correct periods.
